// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin controller that shares one combinational
// 4x4 unsigned multiplier among NREQ requesters.
//   NREQ requesters (2..8). IDW is derived from NREQ and must not be overridden.
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   req_valid/req_a/req_b : per-requester strobe and packed 4-bit operands
//   req_ready             : one-hot grant, asserted combinationally in IDLE
//   rsp_valid/rsp_ready   : response handshake; rsp_id/rsp_p held while stalled
//   mul_a/mul_b/mul_p     : connection to the shared mult4x4
//   chk_err               : sticky product self-check error
// Optional feature: define MULT_ARB_CHECK_EN to build the product checker;
// without it chk_err is tied low.
module mult_share_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [4*NREQ-1:0]   req_a,
  input  logic [4*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [7:0]          rsp_p,
  output logic [3:0]          mul_a,
  output logic [3:0]          mul_b,
  input  logic [7:0]          mul_p,
  output logic                chk_err
);

  localparam int unsigned OPW = 4;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state, state_n;
  logic [IDW-1:0]   last;
  logic [OPW-1:0]   op_a, op_b;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_any;
  logic             accept;
  logic [NREQ-1:0]  grant_oh;

  assign mul_a = op_a;
  assign mul_b = op_b;

  // Round-robin search starting just after the last winner.
  always_comb begin
    logic [IDW-1:0] idx;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IDW'((32'(last) + i) % NREQ);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign grant_oh = NREQ'(1) << gnt_idx;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and grant; rst_n gating keeps req_ready low while in reset.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (gnt_any && rst_n) begin
          accept    = 1'b1;
          req_ready = grant_oh;
          state_n   = CALC;
        end
      end
      CALC:    state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, pointer update and response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= IDW'(NREQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      rsp_id    <= '0;
      rsp_p     <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (accept) begin
        op_a   <= req_a[OPW*gnt_idx +: OPW];
        op_b   <= req_b[OPW*gnt_idx +: OPW];
        rsp_id <= gnt_idx;
        last   <= gnt_idx;
      end
      if (state == CALC) begin
        rsp_p     <= mul_p;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef MULT_ARB_CHECK_EN
  logic chk_q;

  // Sticky compare of the shared multiplier result against a local product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= 1'b0;
    end else if (state == CALC && mul_p != ({4'd0, op_a} * {4'd0, op_b})) begin
      chk_q <= 1'b1;
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin controller that shares one combinational `mult4x4` (4x4 unsigned, 8-bit product) among NREQ requesters. It accepts one operand pair per grant over a valid/ready handshake and drives the operands to the shared multiplier. It registers the product and returns it with the requester ID on a single valid/ready response channel. It sits between the requesting engines and the single multiplier instance.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(NREQ), width of requester ID (derived; do not override)

- clk  in  1  clock, rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request strobe
- req_a  in  4*NREQ  operand A; requester i uses bits [4i+3:4i]
- req_b  in  4*NREQ  operand B; same packing as req_a
- req_ready  out  NREQ  one-hot grant/accept; at most one bit high
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  IDW  index of the requester that owns rsp_p
- rsp_p  out  8  registered product
- mul_a  out  4  operand A to shared mult4x4
- mul_b  out  4  operand B to shared mult4x4
- mul_p  in  8  product from shared mult4x4
- chk_err  out  1  sticky self-check error (see Configuration)

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Arbitrate combinationally over req_valid, starting at (last+1) mod NREQ and wrapping.
  - Winner g gets req_ready[g]=1 in the same cycle.
  - On that edge, latch op_a/op_b from slot g, latch id=g, set last=g, and go to CALC.
  - With no req_valid, stay in IDLE with req_ready=0.
- CALC: mul_a=op_a and mul_b=op_b (these are driven from registers in every state). On the edge, capture rsp_p=mul_p, set rsp_valid=1, and go to RESP.
- RESP: hold rsp_valid, rsp_p and rsp_id stable until the cycle where rsp_ready=1. On that edge clear rsp_valid and go to IDLE.
- req_ready is 0 in CALC and RESP. New requests wait and are not queued.
- A requester may drop req_valid before it is granted. The arbiter keeps no per-requester state except `last`.
- Arithmetic: unsigned. The product is full 8 bits (max 15*15=225). No truncation and no overflow.
- Reset values: state=IDLE, last=NREQ-1 (so requester 0 wins first), op_a=op_b=0, mul_a=mul_b=0, rsp_valid=0, rsp_p=0, rsp_id=0, req_ready=0, chk_err=0.
- Reset mid-operation: an in-flight transaction is discarded with no response. After reset deassertion, behaviour is as from power-up.
- rsp_ready while rsp_valid=0 is ignored.

## Timing
- Accept edge k (req_ready & req_valid): rsp_valid=1 after edge k+1.
- Earliest response handshake is at edge k+2. Earliest next accept is at edge k+3.
- Peak throughput is 1 product per 3 cycles with rsp_ready held high.
- Backpressure stretches RESP indefinitely. All outputs stay stable while stalled.
- The mult4x4 path (op regs -> mul_p -> rsp_p) must close in one cycle.
- Fairness: with all NREQ requesting continuously, each is served exactly once per NREQ grants.

## Configuration
- MULT_ARB_CHECK_EN defined:
  - In CALC, compare mul_p against an internal op_a*op_b.
  - On mismatch, set chk_err=1. It is sticky until rst_n.
- MULT_ARB_CHECK_EN undefined: no checker logic and chk_err is tied 0. The port remains present in both builds.

## Test plan
- Reset then single request: req_valid=0001, slot0 A=3 B=5, rsp_ready=1 -> req_ready=0001 for 1 cycle; rsp_valid high 2 cycles later with rsp_p=15, rsp_id=0; next accept no earlier than 3 cycles after the first.
- Max operands: slot2 A=15 B=15 -> rsp_p=225, rsp_id=2; A=0 B=9 -> rsp_p=0.
- Round-robin: req_valid=1111 held, slot i A=i+1 B=2, rsp_ready=1 -> grant order 0,1,2,3,0 and rsp_p 2,4,6,8,2.
- Backpressure: grant slot1 A=10 B=6, rsp_ready=0 for 5 cycles -> rsp_valid, rsp_p=60, rsp_id=1 stable; req_ready=0 throughout; release -> rsp_valid drops after one handshake edge.
- Reset mid-op: assert rst_n=0 during CALC -> all outputs 0 immediately; no response issued; first grant after reset goes to requester 0.
- MULT_ARB_CHECK_EN build: force mul_p to a wrong value (e.g. 3*5 returns 16) -> chk_err=1 and stays 1 until rst_n; correct model -> chk_err stays 0 across 256 exhaustive A/B pairs.
